// File: rtl/instr_fetch.sv
// Instruction fetch stage with integrated IF/ID pipeline register.
// Issues reads to a one-cycle-latency instruction memory, absorbs pipeline
// stalls in a one-entry skid buffer, and handles redirects and HALT.
module instr_fetch #(
    parameter logic [21:0] RESET_PC  = 22'h000000,
    parameter logic [31:0] NOP_INSTR = 32'h7800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [21:0] redirect_pc,
    input  logic        hlt_ID,
    output logic [21:0] imem_addr,
    output logic        imem_rd_en,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr_IF,
    output logic [21:0] PC_IF,
    output logic        valid_IF
);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t      state, state_next;
    logic [21:0] pc_q;
    logic        inflight;
    logic [21:0] inflight_pc;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [21:0] skid_pc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and memory read issue (flush > stall > hlt_ID > normal)
    always_comb begin
        state_next = state;
        imem_rd_en = 1'b0;
        imem_addr  = RESET_PC;
        if (rst_n) begin
            imem_rd_en = ((state == RUN) && !stall) || flush;
            imem_addr  = flush ? redirect_pc : pc_q;
            if (flush) begin
                state_next = RUN;
            end else if (!stall && (state == RUN) && hlt_ID) begin
                state_next = HALTED;
            end
        end
    end

    // PC advance and in-flight tracking; a read issued while halting is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_rd_en && (state_next == RUN);
            if (imem_rd_en) begin
                pc_q        <= imem_addr + 22'd1;
                inflight_pc <= imem_addr;
            end
        end
    end

    // Skid buffer and IF/ID output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            instr_IF   <= NOP_INSTR;
            PC_IF      <= '0;
            valid_IF   <= 1'b0;
        end else if (flush) begin
            skid_valid <= 1'b0;
            instr_IF   <= NOP_INSTR;
            valid_IF   <= 1'b0;
        end else if (stall) begin
            if (inflight) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_instr;
                skid_pc    <= inflight_pc;
            end
        end else if ((state == HALTED) || hlt_ID) begin
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            skid_valid <= 1'b0;
            instr_IF   <= skid_instr;
            PC_IF      <= skid_pc;
            valid_IF   <= 1'b1;
        end else if (inflight) begin
            instr_IF   <= imem_instr;
            PC_IF      <= inflight_pc;
            valid_IF   <= 1'b1;
        end else begin
            instr_IF   <= NOP_INSTR;
            valid_IF   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized
// stall/flush/halt traffic against a queue-based reference model.
module tb_instr_fetch;

    localparam logic [21:0] RST_PC = 22'h000000;
    localparam logic [31:0] NOP    = 32'h7800_0000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic [21:0] redirect_pc;
    logic        hlt_ID;
    logic [21:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_instr;
    logic [31:0] instr_IF;
    logic [21:0] PC_IF;
    logic        valid_IF;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference model state
    logic [21:0] m_pc;
    logic [21:0] m_q[$];
    bit          m_halt;
    logic [31:0] m_instr;
    logic [21:0] m_pcif;
    logic        m_valid;

    instr_fetch #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .flush      (flush),
        .redirect_pc(redirect_pc),
        .hlt_ID     (hlt_ID),
        .imem_addr  (imem_addr),
        .imem_rd_en (imem_rd_en),
        .imem_instr (imem_instr),
        .instr_IF   (instr_IF),
        .PC_IF      (PC_IF),
        .valid_IF   (valid_IF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [21:0] a);
        return {~a[9:0], a};
    endfunction

    // Synchronous one-cycle-latency instruction memory
    always @(posedge clk) begin
        if (imem_rd_en) imem_instr <= word_of(imem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = RST_PC;
        m_q.delete();
        m_halt  = 1'b0;
        m_instr = NOP;
        m_pcif  = '0;
        m_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_instr"}, instr_IF, NOP);
        check_eq({tag, "_pc"}, {10'd0, PC_IF}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, valid_IF}, 32'd0);
        check_eq({tag, "_rden"}, {31'd0, imem_rd_en}, 32'd0);
        check_eq({tag, "_addr"}, {10'd0, imem_addr}, {10'd0, RST_PC});
    endtask

    // One clock cycle: drive inputs, check at negedge, advance model at posedge
    task automatic cycle(input logic s, input logic f, input logic [21:0] rp, input logic h);
        logic        exp_rd;
        logic [21:0] exp_addr;
        logic [21:0] p;
        stall       = s;
        flush       = f;
        redirect_pc = rp;
        hlt_ID      = h;
        exp_rd   = (!m_halt && !s) || f;
        exp_addr = f ? rp : m_pc;
        @(negedge clk);
        check_eq("instr_IF", instr_IF, m_instr);
        check_eq("PC_IF", {10'd0, PC_IF}, {10'd0, m_pcif});
        check_eq("valid_IF", {31'd0, valid_IF}, {31'd0, m_valid});
        check_eq("imem_rd_en", {31'd0, imem_rd_en}, {31'd0, exp_rd});
        check_eq("imem_addr", {10'd0, imem_addr}, {10'd0, exp_addr});
        @(posedge clk);
        if (f) begin
            m_q.delete();
            m_q.push_back(rp);
            m_pc    = rp + 22'd1;
            m_instr = NOP;
            m_valid = 1'b0;
            m_halt  = 1'b0;
        end else if (s) begin
            // everything holds; a returning word is retained in the queue
        end else if (m_halt) begin
            m_q.delete();
        end else if (h) begin
            m_halt = 1'b1;
            m_q.delete();
            m_pc   = m_pc + 22'd1;
        end else begin
            if (m_q.size() > 0) begin
                p       = m_q.pop_front();
                m_instr = word_of(p);
                m_pcif  = p;
                m_valid = 1'b1;
            end else begin
                m_instr = NOP;
                m_valid = 1'b0;
            end
            m_q.push_back(m_pc);
            m_pc = m_pc + 22'd1;
        end
        #1;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        stall       = 1'b0;
        flush       = 1'b0;
        redirect_pc = '0;
        hlt_ID      = 1'b0;
        imem_instr  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Straight-line fetch
        run(10);

        // Stall three cycles with a word in flight
        for (int unsigned i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0, 1'b0);
        run(5);

        // Redirect with a word in flight
        cycle(1'b0, 1'b1, 22'h000100, 1'b0);
        run(4);

        // Flush while stalled with the skid full
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 22'h000200, 1'b0);
        run(4);

        // HALT, frozen for 20 cycles, then flush coinciding with hlt_ID
        cycle(1'b0, 1'b0, '0, 1'b1);
        for (int unsigned i = 0; i < 20; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 22'h000040, 1'b1);
        run(5);

        // PC wrap
        cycle(1'b0, 1'b1, 22'h3FFFFF, 1'b0);
        run(5);

        // Randomized traffic
        for (int unsigned i = 0; i < 400; i++) begin
            logic        s, f, h;
            logic [21:0] rp;
            s  = ($urandom_range(0, 99) < 25);
            f  = ($urandom_range(0, 99) < 8);
            h  = ($urandom_range(0, 99) < 4);
            rp = ($urandom_range(0, 3) == 0) ? 22'h3FFFFF - 22'($urandom_range(0, 2))
                                             : 22'($urandom);
            cycle(s, f, rp, h);
        end

        // Async reset mid-stall with the skid full
        flush = 1'b0;
        run(4);
        cycle(1'b1, 1'b0, '0, 1'b0);
        stall = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;
        run(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
